inst_fetch_queue: RTL and testbench

//   Parametrised successor to the single-request IF stage. Decouples fetch from decode for the core's SRAM-like inst port.

---
 rtl/inst_fetch_queue_pkg.sv | 31 +++
 rtl/inst_fetch_queue_fifo.sv | 78 +++++++
 rtl/inst_fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types, encodings and width helpers for the instruction fetch queue.
package inst_fetch_queue_pkg;

  // Request handshake state: IDLE may start a request, HOLD keeps it stable until accepted.
  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_HOLD = 1'b1
  } req_state_e;

  // SRAM transfer size encoding for a 32-bit word access.
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

  // First fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Pointer width for an n-entry ring; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the {pc, inst} bundle handed to decode.
  function automatic int unsigned fs2ds_len(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Small synchronous FIFO with show-ahead head and a synchronous clear.
// Used both as the in-flight PC queue and as the fetched-instruction buffer.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Ring increment; explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers and occupancy; clear wins over any push or pop in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !clear;
    do_push  = push && !clear && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled instruction fetch: keeps several SRAM requests in flight, buffers
// returned instructions for decode, and drops stale responses after a redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              inst_sram_req,
  output logic              inst_sram_wr,
  output logic [1:0]        inst_sram_size,
  output logic [3:0]        inst_sram_wstrb,
  output logic [ADDR_W-1:0] inst_sram_addr,
  output logic [DATA_W-1:0] inst_sram_wdata,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst
);

  localparam int unsigned LW       = cnt_w(MAX_OUTSTANDING);
  localparam int unsigned BW       = cnt_w(DEPTH);
  localparam int unsigned SW       = BW + 2;
  localparam int unsigned BUNDLE_W = fs2ds_len(ADDR_W, DATA_W);

  req_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              redirect_pend_q, redirect_pend_d;
  logic [LW-1:0]     live_q, live_d;
  logic [LW-1:0]     cancel_q, cancel_d;

  logic [SW-1:0]       live_w, cancel_w, buf_w, inflight_w;
  logic                issue_ok;
  logic                accept, accept_cancel, accept_live;
  logic                resp_drop, resp_keep;
  logic                buf_push, buf_pop;
  logic [ADDR_W-1:0]   pcq_head;
  logic [LW-1:0]       pcq_cnt;
  logic [BUNDLE_W-1:0] buf_head;
  logic [BW-1:0]       buf_cnt;

  // Write-side SRAM fields are constant for an instruction port.
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = '0;

  // Handshake decode: when a request may start, what gets accepted, and what happens to a response.
  always_comb begin
    live_w     = SW'(live_q);
    cancel_w   = SW'(cancel_q);
    buf_w      = SW'(buf_cnt);
    inflight_w = live_w + cancel_w;
    // A new request reserves a buffer slot so its response can never find the buffer full.
    issue_ok   = !reset && !flush
               && (inflight_w < SW'(MAX_OUTSTANDING))
               && ((live_w + buf_w) < SW'(DEPTH));
    inst_sram_req  = (state_q == REQ_HOLD) || issue_ok;
    inst_sram_addr = (state_q == REQ_HOLD) ? hold_addr_q : fetch_pc_q;
    accept         = inst_sram_req && inst_sram_addr_ok;
    // A request accepted during or after a redirect belongs to the old stream.
    accept_cancel  = accept && (flush || redirect_pend_q);
    accept_live    = accept && !accept_cancel;
    resp_drop      = inst_sram_data_ok && (cancel_q != '0);
    resp_keep      = inst_sram_data_ok && (cancel_q == '0) && (pcq_cnt != '0);
    buf_push       = resp_keep && !flush;
    out_valid      = (buf_cnt != '0) && !flush;
    buf_pop        = out_valid && out_ready;
  end

  // Request FSM, fetch PC and in-flight accounting (next-state).
  always_comb begin
    state_d         = state_q;
    hold_addr_d     = hold_addr_q;
    redirect_pend_d = redirect_pend_q;
    fetch_pc_d      = fetch_pc_q;
    live_d          = live_q;
    cancel_d        = cancel_q;

    case (state_q)
      REQ_IDLE: begin
        if (inst_sram_req && !inst_sram_addr_ok) begin
          state_d     = REQ_HOLD;
          hold_addr_d = fetch_pc_q;
        end
      end
      REQ_HOLD: begin
        if (inst_sram_addr_ok) begin
          state_d         = REQ_IDLE;
          redirect_pend_d = 1'b0;
        end
      end
      default: state_d = REQ_IDLE;
    endcase

    if (flush) begin
      // Everything still owed by the SRAM becomes a discard, less any response landing now.
      fetch_pc_d = flush_pc;
      live_d     = '0;
      cancel_d   = LW'(inflight_w + SW'(accept) - SW'(resp_drop | resp_keep));
      if ((state_q == REQ_HOLD) && !inst_sram_addr_ok) begin
        redirect_pend_d = 1'b1;
      end
    end else begin
      if (accept_live) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      live_d   = LW'(live_w + SW'(accept_live) - SW'(resp_keep));
      cancel_d = LW'(cancel_w + SW'(accept_cancel) - SW'(resp_drop));
    end
  end

  // Request FSM and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= REQ_IDLE;
      fetch_pc_q      <= RESET_PC;
      hold_addr_q     <= RESET_PC;
      redirect_pend_q <= 1'b0;
      live_q          <= '0;
      cancel_q        <= '0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      hold_addr_q     <= hold_addr_d;
      redirect_pend_q <= redirect_pend_d;
      live_q          <= live_d;
      cancel_q        <= cancel_d;
    end
  end

  // PCs of live requests in issue order; responses return in the same order.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (accept_live),
    .push_data (inst_sram_addr),
    .pop       (resp_keep),
    .head_data (pcq_head),
    .count     (pcq_cnt)
  );

  // Fetched {pc, inst} pairs waiting for decode.
  fetch_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (buf_push),
    .push_data ({pcq_head, inst_sram_rdata}),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_cnt)
  );

  assign out_pc   = buf_head[BUNDLE_W-1 -: ADDR_W];
  assign out_inst = buf_head[DATA_W-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and randomised checks for inst_fetch_queue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_inst_fetch_queue;

  localparam logic [31:0] P       = 32'h1c000000;
  localparam logic [31:0] K       = 32'h000000A5;
  localparam logic [31:0] J       = 32'hdeadbeef;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          rst;
    bit          fl;
    logic [31:0] fpc;
    bit          aok;
    bit          dok;
    logic [31:0] rd;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc;
    int          e_live;
    int          e_cancel;
    int          e_buf;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  vec_t        vecs[$];
  pend_t       pq[$];
  logic [31:0] exp_pc;
  int          last_due;
  int          pops;
  logic        prev_hold;
  logic [31:0] prev_addr;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_inst          (out_inst)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit fl, input logic [31:0] fpc,
                              input bit aok, input bit dok, input logic [31:0] rd, input bit rdy,
                              input bit e_req, input logic [31:0] e_addr,
                              input bit e_ov, input logic [31:0] e_pc,
                              input int e_live, input int e_cancel, input int e_buf);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fpc = fpc; v.aok = aok; v.dok = dok; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
    v.e_live = e_live; v.e_cancel = e_cancel; v.e_buf = e_buf;
    return v;
  endfunction

  // Hold reset for one cycle, check the reset state, release just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0; flush_pc = '0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst.req", 64'(inst_sram_req), 64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.fetch_pc", 64'(dut.fetch_pc_q), 64'(P));
    chk("rst.live", 64'(dut.live_q), 64'(0));
    chk("rst.cancel", 64'(dut.cancel_q), 64'(0));
    chk("rst.buf_cnt", 64'(dut.buf_cnt), 64'(0));
    chk("rst.redirect_pend", 64'(dut.redirect_pend_q), 64'(0));
    chk("rst.tied", 64'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
        64'({1'b0, 2'b10, 4'b0000, 32'h0}));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs, compare mid-cycle, advance past the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    if (v.rst) do_reset();
    flush = v.fl; flush_pc = v.fpc; inst_sram_addr_ok = v.aok; inst_sram_data_ok = v.dok;
    inst_sram_rdata = v.rd; out_ready = v.rdy;
    @(negedge clk);
    $display("vec %s: req=%0b addr=%h out_valid=%0b out_pc=%h live=%0d cancel=%0d buf=%0d",
             tag, inst_sram_req, inst_sram_addr, out_valid, out_pc,
             dut.live_q, dut.cancel_q, dut.buf_cnt);
    chk({tag, ".req"}, 64'(inst_sram_req), 64'(v.e_req));
    if (v.e_req) chk({tag, ".addr"}, 64'(inst_sram_addr), 64'(v.e_addr));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.e_ov));
    if (v.e_ov) begin
      chk({tag, ".out_pc"}, 64'(out_pc), 64'(v.e_pc));
      chk({tag, ".out_inst"}, 64'(out_inst), 64'(v.e_pc ^ K));
    end
    chk({tag, ".live"}, 64'(dut.live_q), 64'(v.e_live));
    chk({tag, ".cancel"}, 64'(dut.cancel_q), 64'(v.e_cancel));
    chk({tag, ".buf_cnt"}, 64'(dut.buf_cnt), 64'(v.e_buf));
    @(posedge clk); #1;
  endtask

  initial begin
    // Streaming after reset: addr_ok every cycle, data_ok one cycle later.
    //           rst fl fpc aok dok rdata        rdy req addr    ov pc      lv cn bf
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,           1,  1, P,      0, 0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, P ^ K,       1,  1, P + 4,  0, 0,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, (P + 4) ^ K, 1,  1, P + 8,  1, P,       1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, (P + 8) ^ K, 1,  1, P + 12, 1, P + 4,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, (P + 12) ^ K, 1, 1, P + 16, 1, P + 8,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,           1,  1, P + 16, 1, P + 12,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,           1,  1, P + 16, 0, 0,       0, 0, 0));
    // Decode stalled: buffer fills to 4, req stops, first pop frees a slot.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,           0,  1, P,      0, 0,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, P ^ K,       0,  1, P + 4,  0, 0,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, (P + 4) ^ K, 0,  1, P + 8,  1, P,       1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, (P + 8) ^ K, 0,  1, P + 12, 1, P,       1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, (P + 12) ^ K, 0, 0, 0,      1, P,       1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0,  0, 0,      1, P,       0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1,  0, 0,      1, P,       0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0,  1, P + 16, 1, P + 4,   0, 0, 3));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("t%0d", i));

    // Two requests in flight, then a redirect: both responses are dropped.
    apply(mk(1, 0, 0,            1, 0, 0,            1, 1, P,            0, 0,            0, 0, 0), "s3.0");
    apply(mk(0, 0, 0,            1, 0, 0,            1, 1, P + 4,        0, 0,            1, 0, 0), "s3.1");
    apply(mk(0, 1, 32'h1c000100, 0, 0, 0,            1, 0, 0,            0, 0,            2, 0, 0), "s3.2");
    apply(mk(0, 0, 0,            0, 1, J,            1, 0, 0,            0, 0,            0, 2, 0), "s3.3");
    apply(mk(0, 0, 0,            1, 1, J,            1, 1, 32'h1c000100, 0, 0,            0, 1, 0), "s3.4");
    apply(mk(0, 0, 0,            0, 1, 32'h1c0001a5, 1, 1, 32'h1c000104, 0, 0,            1, 0, 0), "s3.5");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, 32'h1c000104, 1, 32'h1c000100, 0, 0, 1), "s3.6");

    // Redirect while a request is held: address stays put, its response is dropped.
    apply(mk(1, 0, 0,            0, 0, 0,            1, 1, P,            0, 0,            0, 0, 0), "s4.0");
    apply(mk(0, 1, 32'h1c000200, 0, 0, 0,            1, 1, P,            0, 0,            0, 0, 0), "s4.1");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, P,            0, 0,            0, 0, 0), "s4.2");
    apply(mk(0, 0, 0,            1, 0, 0,            1, 1, P,            0, 0,            0, 0, 0), "s4.3");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, 32'h1c000200, 0, 0,            0, 1, 0), "s4.4");
    apply(mk(0, 0, 0,            1, 1, J,            1, 1, 32'h1c000200, 0, 0,            0, 1, 0), "s4.5");
    apply(mk(0, 0, 0,            0, 1, 32'h1c0002a5, 1, 1, 32'h1c000204, 0, 0,            1, 0, 0), "s4.6");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, 32'h1c000204, 1, 32'h1c000200, 0, 0, 1), "s4.7");

    // Redirect in the same cycle as addr_ok and data_ok, with a valid head pending.
    apply(mk(1, 0, 0,            1, 0, 0,            0, 1, P,            0, 0,            0, 0, 0), "s5.0");
    apply(mk(0, 0, 0,            1, 1, P ^ K,        0, 1, P + 4,        0, 0,            1, 0, 0), "s5.1");
    apply(mk(0, 0, 0,            0, 0, 0,            0, 1, P + 8,        1, P,            1, 0, 1), "s5.2");
    apply(mk(0, 1, 32'h1c000300, 1, 1, J,            1, 1, P + 8,        0, 0,            1, 0, 1), "s5.3");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, 32'h1c000300, 0, 0,            0, 1, 0), "s5.4");
    apply(mk(0, 0, 0,            1, 1, J,            1, 1, 32'h1c000300, 0, 0,            0, 1, 0), "s5.5");
    apply(mk(0, 0, 0,            0, 1, 32'h1c0003a5, 1, 1, 32'h1c000304, 0, 0,            1, 0, 0), "s5.6");
    apply(mk(0, 0, 0,            0, 0, 0,            1, 1, 32'h1c000304, 1, 32'h1c000300, 0, 0, 1), "s5.7");

    // Random handshake latencies and redirects against an in-order PC scoreboard.
    do_reset();
    exp_pc    = P;
    last_due  = -1;
    pops      = 0;
    prev_hold = 1'b0;
    prev_addr = '0;
    pq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int d;
      flush = ($urandom_range(0, 24) == 0);
      flush_pc = ($urandom_range(0, 3) == 0) ? 32'hfffffff8
                                             : (P + 32'($urandom_range(0, 255) << 2));
      inst_sram_addr_ok = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inst_sram_data_ok = (pq.size() != 0) && (pq[0].due <= cyc);
      if (inst_sram_data_ok) inst_sram_rdata = pq[0].a ^ K;
      else inst_sram_rdata = $urandom;
      @(negedge clk);
      chk("rand.inflight_le_max", 64'(int'(dut.live_q) + int'(dut.cancel_q) <= MAX_OUT), 64'(1));
      if (prev_hold) begin
        chk("rand.hold_req", 64'(inst_sram_req), 64'(1));
        chk("rand.hold_addr", 64'(inst_sram_addr), 64'(prev_addr));
      end
      if (inst_sram_data_ok) void'(pq.pop_front());
      if (inst_sram_req && inst_sram_addr_ok) begin
        d = cyc + $urandom_range(1, 5);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pq.push_back('{a: inst_sram_addr, due: d});
      end
      if (out_valid && out_ready) begin
        $display("pop pc=%h inst=%h", out_pc, out_inst);
        chk("rand.out_pc", 64'(out_pc), 64'(exp_pc));
        chk("rand.out_inst", 64'(out_inst), 64'(exp_pc ^ K));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (flush) begin
        chk("rand.flush_no_valid", 64'(out_valid), 64'(0));
        exp_pc = flush_pc;
      end
      prev_hold = inst_sram_req && !inst_sram_addr_ok;
      prev_addr = inst_sram_addr;
      @(posedge clk); #1;
    end
    chk("rand.progress", 64'(pops > 100), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
